req_queue: RTL and testbench
============================

REQ_QUEUE -- requirements
Module: req_queue

Interface
REQ-001 Parameter DEPTH, default 8: queue entries; power of two, 2..64.
REQ-002 Parameter BANK_W, default 5: bank address width.
REQ-003 Parameter ROW_W, default 16: row address width.
REQ-004 Parameter COL_W, default 10: column address width; ADDR_W = BANK_W+ROW_W+COL_W.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 req_valid  input  1  host request present.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  {bank, row, col}, bank in MSBs.
REQ-010 req_ready  output  1  queue can accept; equals !full.
REQ-011 rd_valid  output  1  head entry valid and is a read.
REQ-012 wr_valid  output  1  head entry valid and is a write.
REQ-013 ppl  output  1  entry behind head hits same bank, row and op as head.
REQ-014 head_addr  output  ADDR_W  address of head entry.
REQ-015 ctrl_ready  input  1  controller consumes head this cycle.
REQ-016 count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-017 Push on a cycle with req_valid && req_ready; entry {we, addr} is written at the tail, and the tail pointer increments modulo DEPTH.
REQ-018 Pop on a cycle with ctrl_ready && (rd_valid || wr_valid); the head pointer increments modulo DEPTH; ctrl_ready with an empty queue is ignored.
REQ-019 Storage is registered; a pushed entry is visible at the outputs on the cycle after the push (1-cycle latency), including when the queue was empty.
REQ-020 rd_valid, wr_valid, ppl and head_addr are combinational decodes of the head/head+1 storage and count; rd_valid and wr_valid are never both 1.
REQ-021 ppl = 1 only when count >= 2, bank and row of head+1 equal those of head, and the we of head+1 equals the we of head; otherwise ppl = 0.
REQ-022 Column bits never affect ppl.
REQ-023 full = (count == DEPTH); when full, req_ready = 0 and no push occurs, even if a pop happens in the same cycle.
REQ-024 Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
REQ-025 Simultaneous push and pop with count == 1: the new entry becomes the head on the next cycle.
REQ-026 Pointer wrap from DEPTH-1 to 0 is seamless; ppl compares across the wrap boundary.
REQ-027 An entry's content is never modified after it is pushed; an entry is only ever removed by a pop.

Reset
REQ-028 While rst = 0 at a clock edge: head pointer, tail pointer and count are cleared to 0.
REQ-029 Reset values: req_ready = 0 during reset and 1 on the first cycle after reset; rd_valid, wr_valid, ppl = 0; head_addr = 0.
REQ-030 Storage array contents are not reset; outputs depend on storage only when count != 0.
REQ-031 Reset mid-operation discards all queued entries with no pop indication; pushes and pops are ignored during reset.

Configuration
REQ-032 Macro REQ_QUEUE_PPL_EN defined: ppl follows REQ-021, allowing the controller to chain page-hit accesses without precharge.
REQ-033 REQ_QUEUE_PPL_EN undefined: ppl is tied to 0, the head+1 compare logic is not compiled, and every access is closed-page (auto-precharge).

Structure
REQ-034 Shared package ddr_ctrl_pkg holds the BANK_W/ROW_W/COL_W defaults, the op encoding (OP_RD = 0, OP_WR = 1) and the packed request entry type {we, bank, row, col}.
REQ-035 One sub-module, req_q_mem: DEPTH x (1+ADDR_W) register array with one write port and two combinational read ports (head, head+1).

Verification
REQ-036 Reset, then push a read to bank 2, row 0x0010, col 5 -> the next cycle rd_valid = 1, wr_valid = 0, ppl = 0, count = 1; ctrl_ready pulse -> count = 0, rd_valid = 0.
REQ-037 Push writes to (bank 1, row 0x0040, col 0) and (bank 1, row 0x0040, col 8) -> ppl = 1 with the first at head; after one pop ppl = 0 and wr_valid = 1.
REQ-038 Push a read and then a write to the same bank/row -> ppl = 0; push a read to bank 3 after a read to bank 1 with the same row -> ppl = 0.
REQ-039 Push DEPTH = 8 entries with ctrl_ready = 0 -> count = 8 and req_ready = 0; a 9th req_valid with a concurrent pop is rejected and count becomes 7; order is preserved across a 12-push/12-pop wrap.
REQ-040 Queue holding 3 entries, assert rst = 0 for one cycle -> count = 0, rd_valid = wr_valid = ppl = 0; a fresh push appears 1 cycle later.
REQ-041 Build without REQ_QUEUE_PPL_EN and repeat REQ-037 -> ppl remains 0 throughout.

Source files
------------

// File: rtl/ddr_ctrl_pkg.sv
// Shared DDR controller definitions: address field widths, op encoding and
// the packed request entry layout {we, bank, row, col}.
package ddr_ctrl_pkg;

   localparam int BANK_W_DEF = 5;
   localparam int ROW_W_DEF  = 16;
   localparam int COL_W_DEF  = 10;
   localparam int ADDR_W_DEF = BANK_W_DEF + ROW_W_DEF + COL_W_DEF;

   // Op encoding carried in the entry's we bit.
   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   typedef struct packed {
      logic                  we;
      logic [BANK_W_DEF-1:0] bank;
      logic [ROW_W_DEF-1:0]  row;
      logic [COL_W_DEF-1:0]  col;
   } req_entry_t;

   // Build an entry from its fields (default widths).
   function automatic req_entry_t make_entry(input logic                  we,
                                             input logic [BANK_W_DEF-1:0] bank,
                                             input logic [ROW_W_DEF-1:0]  row,
                                             input logic [COL_W_DEF-1:0]  col);
      req_entry_t e;
      e.we   = we;
      e.bank = bank;
      e.row  = row;
      e.col  = col;
      return e;
   endfunction

endpackage

// File: rtl/req_q_mem.sv
// Request queue storage: DEPTH x W register array, one write port and two
// combinational read ports (head and head+1). Contents are not reset.
module req_q_mem
   import ddr_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 1 + ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_ptr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_ptr0,
   output logic [W-1:0]             rd_data0,
   input  logic [$clog2(DEPTH)-1:0] rd_ptr1,
   output logic [W-1:0]             rd_data1
);

   logic [W-1:0] mem [DEPTH];

   // Write the tail entry; an entry is never rewritten until popped and reused.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data0 = mem[rd_ptr0];
   assign rd_data1 = mem[rd_ptr1];

endmodule

// File: rtl/req_queue.sv
// DDR request queue: in-order FIFO of {we, addr} host requests with a
// page-hit lookahead (ppl) comparing the head and the entry behind it.
// Build option: define REQ_QUEUE_PPL_EN to enable the ppl compare; when
// undefined ppl is tied to 0 and every access is treated as closed-page.
//
// Handshake: a push happens on a cycle where req_valid && req_ready
// (req_ready = !full, and 0 during reset); a pop happens on a cycle where
// ctrl_ready && (rd_valid || wr_valid). ctrl_ready on an empty queue is
// ignored. A full queue accepts nothing, even when popping that cycle.
module req_queue
   import ddr_ctrl_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int BANK_W = BANK_W_DEF,
   parameter int ROW_W  = ROW_W_DEF,
   parameter int COL_W  = COL_W_DEF,
   localparam int ADDR_W = BANK_W + ROW_W + COL_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   req_ready,
   output logic                   rd_valid,
   output logic                   wr_valid,
   output logic                   ppl,
   output logic [ADDR_W-1:0]      head_addr,
   input  logic                   ctrl_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int ENT_W = 1 + ADDR_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W-1:0] next_ptr;
   logic [ENT_W-1:0] head_entry;
   logic [ENT_W-1:0] next_entry;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             head_we;

   assign next_ptr  = head_ptr + 1'b1;
   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign req_ready = rst & ~full;
   assign push      = req_valid & req_ready;
   assign pop       = ctrl_ready & ~empty;

   req_q_mem #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_mem (
      .clk      (clk),
      .wr_en    (push),
      .wr_ptr   (tail_ptr),
      .wr_data  ({req_we, req_addr}),
      .rd_ptr0  (head_ptr),
      .rd_data0 (head_entry),
      .rd_ptr1  (next_ptr),
      .rd_data1 (next_entry)
   );

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + 1'b1;
         if (pop)  head_ptr <= head_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_we = head_entry[ENT_W-1];

   // Head decode; storage is only looked at while the queue is non-empty.
   always_comb begin
      rd_valid  = ~empty & (head_we == OP_RD);
      wr_valid  = ~empty & (head_we == OP_WR);
      head_addr = empty ? '0 : head_entry[ADDR_W-1:0];
   end

`ifdef REQ_QUEUE_PPL_EN
   // Page-hit lookahead: same op, bank and row in head and head+1; column ignored.
   logic unused_next_col;
   assign unused_next_col = ^next_entry[COL_W-1:0];

   always_comb begin
      ppl = (count >= CNT_W'(2)) &&
            (head_entry[ENT_W-1:COL_W] == next_entry[ENT_W-1:COL_W]);
   end
`else
   // Closed-page build: no lookahead, head+1 read port left unused.
   logic unused_next_entry;
   assign unused_next_entry = ^next_entry;

   always_comb begin
      ppl = 1'b0;
   end
`endif

endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue: a vector table for single-cycle behaviour
// plus hand-written sequences for full/wrap and mid-operation reset.
module tb_req_queue;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 31;
`ifdef REQ_QUEUE_PPL_EN
   localparam bit PPL_ON = 1'b1;
`else
   localparam bit PPL_ON = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              rd_valid;
   logic              wr_valid;
   logic              ppl;
   logic [ADDR_W-1:0] head_addr;
   logic              ctrl_ready;
   logic [3:0]        count;

   int errors;
   int checks;

   logic [ADDR_W:0] exp_q[$];

   req_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .rd_valid   (rd_valid),
      .wr_valid   (wr_valid),
      .ppl        (ppl),
      .head_addr  (head_addr),
      .ctrl_ready (ctrl_ready),
      .count      (count)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic              rst_n;
      logic              req_valid;
      logic              req_we;
      logic [ADDR_W-1:0] addr;
      logic              ctrl_ready;
      logic              exp_ready;
      logic              exp_rd;
      logic              exp_wr;
      logic              exp_ppl;
      logic [3:0]        exp_count;
      logic [ADDR_W-1:0] exp_addr;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [ADDR_W-1:0] mk(input int bank, input int row, input int col);
      logic [4:0]  b;
      logic [15:0] r;
      logic [9:0]  c;
      b = bank[4:0];
      r = row[15:0];
      c = col[9:0];
      return {b, r, c};
   endfunction

   function automatic vec_t v(input logic rn, input logic rv, input logic we,
                              input logic [ADDR_W-1:0] a, input logic cr,
                              input logic e_rdy, input logic e_rd, input logic e_wr,
                              input logic e_ppl, input int e_cnt,
                              input logic [ADDR_W-1:0] e_a);
      vec_t t;
      t.rst_n = rn; t.req_valid = rv; t.req_we = we; t.addr = a; t.ctrl_ready = cr;
      t.exp_ready = e_rdy; t.exp_rd = e_rd; t.exp_wr = e_wr;
      t.exp_ppl = e_ppl & PPL_ON; t.exp_count = e_cnt[3:0]; t.exp_addr = e_a;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rv, input logic we, input logic [ADDR_W-1:0] a,
                        input logic cr);
      req_valid  = rv;
      req_we     = we;
      req_addr   = a;
      ctrl_ready = cr;
   endtask

   // Compare the head outputs against the model queue (sampled between edges).
   task automatic chk_head(input string tag);
      logic [ADDR_W:0] h;
      logic [ADDR_W:0] n;
      logic            e_ppl;
      chk({tag, " count"}, 64'(count), 64'(exp_q.size()));
      if (exp_q.size() != 0) begin
         h = exp_q[0];
         chk({tag, " head_addr"}, 64'(head_addr), 64'(h[ADDR_W-1:0]));
         chk({tag, " wr_valid"}, 64'(wr_valid), 64'(h[ADDR_W]));
         chk({tag, " rd_valid"}, 64'(rd_valid), 64'(!h[ADDR_W]));
         e_ppl = 1'b0;
         if (exp_q.size() >= 2) begin
            n = exp_q[1];
            e_ppl = PPL_ON && (n[ADDR_W:10] == h[ADDR_W:10]);
         end
         chk({tag, " ppl"}, 64'(ppl), 64'(e_ppl));
      end else begin
         chk({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
         chk({tag, " wr_valid"}, 64'(wr_valid), 64'd0);
      end
   endtask

   initial begin
      logic [ADDR_W-1:0] a_r2, w0, w8, r1, rb1, rb3a, rb3b, e_x, e_y;
      errors = 0;
      checks = 0;
      rst = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0);

      a_r2 = mk(2, 16'h0010, 5);
      w0   = mk(1, 16'h0040, 0);
      w8   = mk(1, 16'h0040, 8);
      r1   = mk(1, 16'h0040, 0);
      rb1  = mk(1, 16'h0022, 3);
      rb3a = mk(3, 16'h0022, 3);
      rb3b = mk(3, 16'h0022, 7);

      //           rst  rv  we  addr  cr   rdy rd  wr  ppl cnt head
      vecs[0]  = v(0,   0,  0,  '0,   0,   0,  0,  0,  0,  0,  '0);
      vecs[1]  = v(1,   1,  0,  a_r2, 0,   1,  1,  0,  0,  1,  a_r2);
      vecs[2]  = v(1,   0,  0,  '0,   1,   1,  0,  0,  0,  0,  '0);
      vecs[3]  = v(1,   1,  1,  w0,   0,   1,  0,  1,  0,  1,  w0);
      vecs[4]  = v(1,   1,  1,  w8,   0,   1,  0,  1,  1,  2,  w0);
      vecs[5]  = v(1,   0,  0,  '0,   1,   1,  0,  1,  0,  1,  w8);
      vecs[6]  = v(1,   0,  0,  '0,   1,   1,  0,  0,  0,  0,  '0);
      vecs[7]  = v(1,   1,  0,  r1,   0,   1,  1,  0,  0,  1,  r1);
      vecs[8]  = v(1,   1,  1,  r1,   0,   1,  1,  0,  0,  2,  r1);
      vecs[9]  = v(1,   0,  0,  '0,   1,   1,  0,  1,  0,  1,  r1);
      vecs[10] = v(1,   0,  0,  '0,   1,   1,  0,  0,  0,  0,  '0);
      vecs[11] = v(1,   1,  0,  rb1,  0,   1,  1,  0,  0,  1,  rb1);
      vecs[12] = v(1,   1,  0,  rb3a, 0,   1,  1,  0,  0,  2,  rb1);
      vecs[13] = v(1,   1,  0,  rb3b, 1,   1,  1,  0,  1,  2,  rb3a);
      vecs[14] = v(1,   0,  0,  '0,   1,   1,  1,  0,  0,  1,  rb3b);
      vecs[15] = v(1,   1,  1,  rb3b, 1,   1,  0,  1,  0,  1,  rb3b);
      vecs[16] = v(1,   0,  0,  '0,   1,   1,  0,  0,  0,  0,  '0);

      // Table-driven single-cycle behaviour
      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst_n;
         drive(vecs[i].req_valid, vecs[i].req_we, vecs[i].addr, vecs[i].ctrl_ready);
         step();
         chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
         chk($sformatf("vec%0d rd_valid", i),  64'(rd_valid),  64'(vecs[i].exp_rd));
         chk($sformatf("vec%0d wr_valid", i),  64'(wr_valid),  64'(vecs[i].exp_wr));
         chk($sformatf("vec%0d ppl", i),       64'(ppl),       64'(vecs[i].exp_ppl));
         chk($sformatf("vec%0d count", i),     64'(count),     64'(vecs[i].exp_count));
         chk($sformatf("vec%0d head_addr", i), 64'(head_addr), 64'(vecs[i].exp_addr));
      end
      drive(1'b0, 1'b0, '0, 1'b0);

      // Fill to DEPTH with no pops
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b1, k[0], mk(k % 4, 16'h0100 + k, k), 1'b0);
         exp_q.push_back({k[0], mk(k % 4, 16'h0100 + k, k)});
         step();
      end
      drive(1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("full count", 64'(count), 64'(DEPTH));
      chk("full req_ready", 64'(req_ready), 64'd0);
      chk_head("full");

      // 9th request with a concurrent pop must be rejected
      drive(1'b1, 1'b1, mk(9, 16'h0999, 9), 1'b1);
      #1;
      chk("full+pop req_ready", 64'(req_ready), 64'd0);
      step();
      void'(exp_q.pop_front());
      chk("reject count", 64'(count), 64'd7);
      chk_head("after reject");

      // Drain, checking order
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         #1;
         chk_head($sformatf("drain%0d", k));
         step();
         void'(exp_q.pop_front());
      end
      drive(1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("drained count", 64'(count), 64'd0);

      // 12-push / 12-pop stream crossing the pointer wrap
      for (int j = 0; j < 24; j++) begin
         logic do_push;
         logic do_pop;
         logic [ADDR_W-1:0] a;
         logic we_b;
         do_push = (j < 12);
         do_pop  = (j >= 4);
         a    = mk(j / 2, 16'h0300 + j / 2, j);
         we_b = ((j / 2) % 2) == 1;
         drive(do_push, we_b, a, do_pop);
         #1;
         chk_head($sformatf("stream%0d", j));
         step();
         if (do_pop && exp_q.size() != 0) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back({we_b, a});
      end
      drive(1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("stream end count", 64'(count), 64'd0);

      // Mid-operation reset discards entries; pushes/pops ignored during reset
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, mk(1, 16'h0050, k), 1'b0);
         step();
      end
      chk("pre-reset count", 64'(count), 64'd3);
      rst = 1'b0;
      drive(1'b1, 1'b0, mk(4, 16'h0060, 1), 1'b1);
      step();
      chk("rst count", 64'(count), 64'd0);
      chk("rst rd_valid", 64'(rd_valid), 64'd0);
      chk("rst wr_valid", 64'(wr_valid), 64'd0);
      chk("rst ppl", 64'(ppl), 64'd0);
      chk("rst req_ready", 64'(req_ready), 64'd0);
      chk("rst head_addr", 64'(head_addr), 64'd0);
      rst = 1'b1;
      e_y = mk(6, 16'h0abc, 2);
      drive(1'b1, 1'b0, e_y, 1'b0);
      #1;
      chk("post-rst req_ready", 64'(req_ready), 64'd1);
      chk("post-rst empty rd_valid", 64'(rd_valid), 64'd0);
      step();
      chk("post-rst count", 64'(count), 64'd1);
      chk("post-rst head_addr", 64'(head_addr), 64'(e_y));
      chk("post-rst rd_valid", 64'(rd_valid), 64'd1);
      e_x = '0;
      drive(1'b0, 1'b0, e_x, 1'b1);
      step();
      chk("final count", 64'(count), 64'd0);
      drive(1'b0, 1'b0, '0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
